// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request and hazard/forwarding response bundle for fwd_hazard_unit.
// The master side is the pipeline's ID stage; the slave side is the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic                    id_valid;
    logic [NUM_SRC*AW-1:0]   id_src;
    logic [NUM_SRC-1:0]      id_src_used;
    logic [AW-1:0]           id_rd;
    logic                    id_regwrite;
    logic                    id_memread;
    logic                    flush;
    logic                    stall;
    logic [NUM_SRC*SW-1:0]   fwd_sel;
    logic                    ex_valid;
    logic [CNT_W-1:0]        stall_count;

    modport master (
        output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread, flush,
        input  stall, fwd_sel, ex_valid, stall_count
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_memread, flush,
        output stall, fwd_sel, ex_valid, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall generation for an in-order pipeline.
// Tracks destination tags from EX through DEPTH later stages and picks the nearest producer.
module fwd_hazard_unit #(
    parameter int AW       = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    fwd_hazard_unit_if.slave  bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int unsigned LD_STAGE = LOAD_LAT;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          memread;
    } tag_t;

    tag_t                  tag_q [DEPTH+1];
    tag_t                  tag_d [DEPTH+1];
    logic [NUM_SRC*SW-1:0] fwd_sel_q, fwd_sel_d;
    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic [NUM_SRC*SW-1:0] sel_raw;
    logic                  hazard;
    logic                  stall;
    logic                  accept;

    // Scan stages from farthest to nearest so the lowest matching index wins.
    always_comb begin
        logic [AW-1:0] src;
        logic          hit;
        logic          hit_load;
        logic [SW-1:0] hit_sel;
        logic          hit_early;
        sel_raw = '0;
        hazard  = 1'b0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            src       = bus.id_src[j*AW +: AW];
            hit       = 1'b0;
            hit_load  = 1'b0;
            hit_sel   = '0;
            hit_early = 1'b0;
            for (int unsigned k = DEPTH; k > 0; k--) begin
                if (bus.id_src_used[j] && (src != '0) && tag_q[k-1].valid &&
                    tag_q[k-1].regwrite && (tag_q[k-1].rd == src)) begin
                    hit       = 1'b1;
                    hit_load  = tag_q[k-1].memread;
                    hit_sel   = SW'(k);
                    hit_early = (k < LD_STAGE);
                end
            end
            sel_raw[j*SW +: SW] = hit_sel;
            if (hit && hit_load && hit_early && bus.id_valid)
                hazard = 1'b1;
        end
    end

    assign stall  = hazard & ~bus.flush;
    assign accept = bus.id_valid & ~stall & ~bus.flush;

    always_comb begin
        tag_d[0] = '0;
        if (accept) begin
            tag_d[0].valid    = 1'b1;
            tag_d[0].rd       = bus.id_rd;
            tag_d[0].regwrite = bus.id_regwrite;
            tag_d[0].memread  = bus.id_memread;
        end
        for (int unsigned i = 0; i < DEPTH; i++)
            tag_d[i+1] = tag_q[i];
    end

    always_comb begin
        fwd_sel_d = accept ? sel_raw : '0;
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= DEPTH; i++)
                tag_q[i] <= '0;
            fwd_sel_q     <= '0;
            stall_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i <= DEPTH; i++)
                tag_q[i] <= tag_d[i];
            fwd_sel_q     <= fwd_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_sel     = fwd_sel_q;
    assign bus.ex_valid    = tag_q[0].valid;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed checks of forwarding select, load-use stall, flush priority, reset and counter saturation.
module tb_fwd_hazard_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .DEPTH(2), .CNT_W(16)) b ();
    fwd_hazard_unit_if #(.AW(5), .NUM_SRC(2), .DEPTH(2), .CNT_W(2))  bs ();

    fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .DEPTH(2), .LOAD_LAT(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(b.slave)
    );
    fwd_hazard_unit #(.AW(5), .NUM_SRC(2), .DEPTH(2), .LOAD_LAT(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bs.slave)
    );

    assign bs.id_valid    = b.id_valid;
    assign bs.id_src      = b.id_src;
    assign bs.id_src_used = b.id_src_used;
    assign bs.id_rd       = b.id_rd;
    assign bs.id_regwrite = b.id_regwrite;
    assign bs.id_memread  = b.id_memread;
    assign bs.flush       = b.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        b.id_valid    = v;
        b.id_src      = {s1, s0};
        b.id_src_used = used;
        b.id_rd       = rd;
        b.id_regwrite = rw;
        b.id_memread  = mr;
        b.flush       = fl;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        nop();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        nop();
        reset = 1'b1;
        #1;
        total++; if (b.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid got=%0b exp=0", b.ex_valid); end
        total++; if (b.fwd_sel !== 4'd0) begin bad++; $display("FAIL reset_fwd_sel got=%0h exp=0", b.fwd_sel); end
        total++; if (b.stall_count !== 16'd0) begin bad++; $display("FAIL reset_stall_count got=%0d exp=0", b.stall_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 5'd2, 5'd3, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL reset_release_stall got=%0b exp=0", b.stall); end
        tick();
        total++; if (b.ex_valid !== 1'b1) begin bad++; $display("FAIL reset_first_accept got=%0b exp=1", b.ex_valid); end
    endtask

    task automatic test_ex_forward();
        apply_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd5, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL ex_fwd_stall got=%0b exp=0", b.stall); end
        tick();
        nop();
        total++; if (b.fwd_sel !== 4'b0001) begin bad++; $display("FAIL ex_fwd_sel got=%0h exp=1", b.fwd_sel); end
        total++; if (b.ex_valid !== 1'b1) begin bad++; $display("FAIL ex_fwd_valid got=%0b exp=1", b.ex_valid); end
        tick();
        total++; if (b.ex_valid !== 1'b0) begin bad++; $display("FAIL ex_fwd_bubble got=%0b exp=0", b.ex_valid); end
    endtask

    task automatic test_mem_forward();
        apply_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (b.fwd_sel !== 4'b1010) begin bad++; $display("FAIL mem_fwd_sel got=%0h exp=a", b.fwd_sel); end
        apply_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        tick();
        drive(1'b1, 5'd10, 5'd10, 2'b11, 5'd11, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (b.fwd_sel !== 4'd0) begin bad++; $display("FAIL dist3_fwd_sel got=%0h exp=0", b.fwd_sel); end
        total++; if (b.ex_valid !== 1'b1) begin bad++; $display("FAIL dist3_valid got=%0b exp=1", b.ex_valid); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (b.stall !== 1'b1) begin bad++; $display("FAIL lu_stall_first got=%0b exp=1", b.stall); end
        tick();
        total++; if (b.ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble_valid got=%0b exp=0", b.ex_valid); end
        total++; if (b.fwd_sel !== 4'd0) begin bad++; $display("FAIL lu_bubble_sel got=%0h exp=0", b.fwd_sel); end
        total++; if (b.stall_count !== 16'd1) begin bad++; $display("FAIL lu_count_stall got=%0d exp=1", b.stall_count); end
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL lu_stall_second got=%0b exp=0", b.stall); end
        tick();
        nop();
        total++; if (b.fwd_sel !== 4'b0010) begin bad++; $display("FAIL lu_fwd_sel got=%0h exp=2", b.fwd_sel); end
        total++; if (b.ex_valid !== 1'b1) begin bad++; $display("FAIL lu_ex_valid got=%0b exp=1", b.ex_valid); end
        total++; if (b.stall_count !== 16'd1) begin bad++; $display("FAIL lu_count_after got=%0d exp=1", b.stall_count); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd4, 5'd5, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (b.fwd_sel !== 4'b0101) begin bad++; $display("FAIL nearest_fwd_sel got=%0h exp=5", b.fwd_sel); end
        drive(1'b1, 5'd9, 5'd3, 2'b01, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (b.fwd_sel !== 4'b0001) begin bad++; $display("FAIL used_mask_fwd_sel got=%0h exp=1", b.fwd_sel); end
    endtask

    task automatic test_flush();
        apply_reset();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b1);
        #1;
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0b exp=0", b.stall); end
        tick();
        nop();
        total++; if (b.ex_valid !== 1'b0) begin bad++; $display("FAIL flush_ex_valid got=%0b exp=0", b.ex_valid); end
        total++; if (b.fwd_sel !== 4'd0) begin bad++; $display("FAIL flush_fwd_sel got=%0h exp=0", b.fwd_sel); end
        total++; if (b.stall_count !== 16'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", b.stall_count); end
    endtask

    task automatic test_reg_zero();
        apply_reset();
        drive(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%0b exp=0", b.stall); end
        tick();
        total++; if (b.fwd_sel !== 4'd0) begin bad++; $display("FAIL r0_fwd_sel got=%0h exp=0", b.fwd_sel); end
        total++; if (b.ex_valid !== 1'b1) begin bad++; $display("FAIL r0_ex_valid got=%0b exp=1", b.ex_valid); end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (b.stall !== 1'b1) begin bad++; $display("FAIL mid_pre_stall got=%0b exp=1", b.stall); end
        reset = 1'b1;
        #1;
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%0b exp=0", b.stall); end
        total++; if (b.ex_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%0b exp=0", b.ex_valid); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        total++; if (b.stall !== 1'b0) begin bad++; $display("FAIL mid_release_stall got=%0b exp=0", b.stall); end
        tick();
        nop();
        total++; if (b.ex_valid !== 1'b1) begin bad++; $display("FAIL mid_accept_valid got=%0b exp=1", b.ex_valid); end
        total++; if (b.fwd_sel !== 4'd0) begin bad++; $display("FAIL mid_accept_sel got=%0h exp=0", b.fwd_sel); end
        total++; if (b.stall_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", b.stall_count); end
    endtask

    task automatic test_saturate();
        int exp_sat;
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd2, 5'd1, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
            exp_sat = (k < 3) ? k : 3;
            total++; if (b.stall_count !== 16'(k)) begin bad++; $display("FAIL sat_wide_count got=%0d exp=%0d", b.stall_count, k); end
            total++; if (bs.stall_count !== 2'(exp_sat)) begin bad++; $display("FAIL sat_narrow_count got=%0d exp=%0d", bs.stall_count, exp_sat); end
        end
        nop();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        nop();
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reg_zero();
        test_reset_mid_stall();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
